// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared types and constants for the inverter-bank sweep controller.
//   state_t        : controller states (idle, settling, sampling, finished)
//   DEFAULT_SETTLE : default number of cycles a vector is held before sampling
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_SETTLE = 2;

endpackage

// File: rtl/sweep_settle_timer.sv
// -----------------------------------------------------------------------------
// sweep_settle_timer
// Loadable down-counter with a zero flag. Counts the settle cycles each input
// vector is held before the bank outputs are sampled.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val (takes priority over dec)
//   dec      : decrement by one, saturating at zero
//   load_val : value loaded on load
//   zero     : high while the count is zero
// -----------------------------------------------------------------------------
module sweep_settle_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    // The count register: a load restarts the settle window for a new vector,
    // otherwise it steps down toward zero and parks there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Sequencer that drives every input vector of a WIDTH-lane inverter bank,
// holds each vector SETTLE cycles, samples the bank and compares it against
// the ideal inverse. Accumulates a mismatch count and the first failing vector.
// Parameters:
//   WIDTH  : number of inverter lanes (sweep covers 2^WIDTH vectors)
//   SETTLE : cycles each vector is held before sampling (min 1)
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : begin a sweep (honoured only when idle or done)
//   dut_a         : vector driven into the bank
//   dut_y         : bank outputs
//   busy          : high while sweeping
//   done          : high once the sweep finishes, until next start or reset
//   pass          : with done, 1 when no mismatches were seen
//   err_cnt       : number of mismatching vectors
//   first_err_vec : first mismatching vector, 0 if none
// Build option:
//   GATE_SWEEP_STOP_ON_ERR_EN : when defined, the first mismatch ends the sweep.
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0] first_err_vec
);

    localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    state_t state;
    state_t next_state;
    logic   tmr_load;
    logic   tmr_dec;
    logic   tmr_zero;
    logic   clear_run;
    logic   advance;
    logic   mismatch;
    logic   last_vec;

    sweep_settle_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (RELOAD),
        .zero     (tmr_zero)
    );

    // Any lane that is not the inverse of its input makes the whole vector bad.
    assign mismatch = (dut_y != ~dut_a);
    assign last_vec = (dut_a == '1);

    // State register. Reset always returns to idle, even in the middle of a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. A start is accepted only from idle or
    // done; while sweeping it is simply not looked at, so nothing is queued.
    // The terminal vector always leaves for DONE, so the vector counter
    // never wraps around.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        clear_run  = 1'b0;
        advance    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_SETTLE;
                    tmr_load   = 1'b1;
                    clear_run  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    next_state = S_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    next_state = S_DONE;
                end else begin
                    next_state = S_SETTLE;
                    tmr_load   = 1'b1;
                    advance    = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Vector counter and checker. Clearing happens on the accepted start so a
    // new run never inherits results from the previous one. The first failing
    // vector is captured only while the error count is still zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a         <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else if (clear_run) begin
            dut_a         <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else if (state == S_SAMPLE) begin
            if (mismatch) begin
                err_cnt <= err_cnt + (WIDTH+1)'(1);
                if (err_cnt == '0) begin
                    first_err_vec <= dut_a;
                end
            end
            if (advance) begin
                dut_a <= dut_a + WIDTH'(1);
            end
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sequencer for the inverter lab cells. It drives every input vector of a WIDTH-lane bank of CMOS inverters, waits a programmable settle time, and samples the bank outputs. Each sample is compared against the ideal inverse, and the controller accumulates a mismatch count and the first failing vector. It sits between a lab top-level (start button / testbench) and the gate-level cell under test, replacing hand-written delay-and-toggle stimulus with a clocked, repeatable sweep.

## Interface
- WIDTH, 1: number of inverter lanes driven and checked; sweep covers 2^WIDTH vectors
- SETTLE, 2: clock cycles held per vector before sampling (min 1)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- dut_a  output  WIDTH  vector driven into the inverter bank
- dut_y  input  WIDTH  inverter bank outputs
- busy  output  1  high while sweeping
- done  output  1  high in DONE; held until next start or reset
- pass  output  1  valid when done: 1 if err_cnt == 0
- err_cnt  output  WIDTH+1  number of mismatching vectors
- first_err_vec  output  WIDTH  vector of the first mismatch; 0 if none

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start=1 -> SETTLE:
  - dut_a=0
  - settle counter loaded with SETTLE-1
  - err_cnt, first_err_vec cleared
  - done=0, busy=1
- SETTLE: counter decrements each cycle; at 0 -> SAMPLE.
- SAMPLE: dut_y compared with ~dut_a on all lanes; any lane differing counts as one mismatching vector.
  - On mismatch: err_cnt+1; first_err_vec<=dut_a if err_cnt was 0.
  - If dut_a == 2^WIDTH-1 -> DONE.
  - Else: dut_a+1, reload counter, -> SETTLE.
- DONE: busy=0, done=1, pass=(err_cnt==0); dut_a holds last vector.
- start while busy is ignored; no queuing.
- err_cnt cannot overflow: max value 2^WIDTH fits WIDTH+1 bits.
- Vector counter never wraps: the terminal vector always exits to DONE.

## Timing
- Reset values: dut_a=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0; state IDLE.
- Reset asserted mid-sweep overrides everything: IDLE next edge, all outputs to reset values; no partial result retained.
- Each vector occupies SETTLE+1 cycles: SETTLE in SETTLE, 1 in SAMPLE.
- Cycles from the start edge to done=1: 2^WIDTH*(SETTLE+1).
- dut_y is sampled on the SAMPLE-state edge, i.e. SETTLE+1 cycles after dut_a changed.
- start and rst high together: rst wins.
- start held high through DONE restarts immediately on the next cycle.

## Configuration
- GATE_SWEEP_STOP_ON_ERR_EN:
  - Defined: the first mismatch in SAMPLE goes straight to DONE with err_cnt=1 and first_err_vec=failing vector; remaining vectors are not driven.
  - Undefined: the full sweep always completes and all mismatches are counted.

## Structure
- Package gate_sweep_pkg holds:
  - state_t enum typedef (IDLE, SETTLE, SAMPLE, DONE)
  - DEFAULT_SETTLE constant
- One sub-module, sweep_settle_timer: loadable down-counter with a zero flag, instantiated once; the top holds the FSM, vector counter and checker.

## Test plan
- WIDTH=1, SETTLE=2, ideal inverter: pulse start -> done=1 exactly 6 cycles later, err_cnt=0, pass=1, first_err_vec=0.
- WIDTH=1, dut_y stuck at 0 -> err_cnt=1, first_err_vec=0, pass=0.
- WIDTH=4, SETTLE=1, lane 2 stuck at 1 -> done after 32 cycles, err_cnt=8, first_err_vec=4'b0100.
- Same fault with GATE_SWEEP_STOP_ON_ERR_EN -> done after 10 cycles, err_cnt=1, first_err_vec=4.
- WIDTH=2, start pulsed again while busy -> sweep unaffected, done after 4*(SETTLE+1) cycles from the first start.
- rst=1 while dut_a=2 mid-sweep -> next edge: dut_a=0, busy=0, done=0, err_cnt=0; a fresh start then completes normally.
